// File: rtl/kf_update_semipar_pkg.sv
// Shared constants and schedule encoding for the Kalman measurement-update stage.
package kf_update_semipar_pkg;

  localparam int unsigned FxpN      = 16;
  localparam int unsigned FxpFrac   = 8;
  localparam int unsigned KfUpdLast = 8;

  // Step of the fixed 9-cycle schedule; the name says what happens on the edge that ends it.
  typedef enum logic [3:0] {
    CycHx     = 4'd0,  // load H*x products
    CycErr    = 4'd1,  // innovation e = z - H*x
    CycKe     = 4'd2,  // load K*e products
    CycXpKh0  = 4'd3,  // x_post, load K*H column 0
    CycA0Kh1  = 4'd4,  // (I-KH) column 0, load K*H column 1
    CycA1     = 4'd5,  // (I-KH) column 1
    CycAp0    = 4'd6,  // load A*P column 0
    CycPp0Ap1 = 4'd7,  // P_post column 0, load A*P column 1
    CycPp1Out = 4'(KfUpdLast)  // P_post column 1, publish results
  } upd_cyc_e;

  // Steps on which the multiplier bank captures new products.
  function automatic logic mul_load(input upd_cyc_e c);
    return c inside {CycHx, CycKe, CycXpKh0, CycA0Kh1, CycAp0, CycPp0Ap1};
  endfunction

endpackage

// File: rtl/kf_update_semipar_dot2x2.sv
// Four registered full-precision multipliers with pairwise sums in the 2N domain.
module kf_update_semipar_dot2x2 #(
  parameter int unsigned N = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic signed [N-1:0]   a0,
  input  logic signed [N-1:0]   b0,
  input  logic signed [N-1:0]   a1,
  input  logic signed [N-1:0]   b1,
  input  logic signed [N-1:0]   a2,
  input  logic signed [N-1:0]   b2,
  input  logic signed [N-1:0]   a3,
  input  logic signed [N-1:0]   b3,
  output logic signed [2*N-1:0] s01,
  output logic signed [2*N-1:0] s23
);

  logic signed [2*N-1:0] m0, m1, m2, m3;

  // Product registers; they hold their value when not enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 <= '0;
      m1 <= '0;
      m2 <= '0;
      m3 <= '0;
    end else if (en) begin
      m0 <= (2*N)'(a0) * (2*N)'(b0);
      m1 <= (2*N)'(a1) * (2*N)'(b1);
      m2 <= (2*N)'(a2) * (2*N)'(b2);
      m3 <= (2*N)'(a3) * (2*N)'(b3);
    end
  end

  // Column sums kept at full width; truncation happens at the consumer.
  always_comb begin
    s01 = m0 + m1;
    s23 = m2 + m3;
  end

endmodule

// File: rtl/kf_update_semipar.sv
// Measurement update of the 2x2 fixed-point Kalman filter on a 9-cycle shared-multiplier schedule:
// x_post = x + K(z - Hx), P_post = (I - KH) P.
module kf_update_semipar
  import kf_update_semipar_pkg::*;
#(
  parameter int unsigned N    = FxpN,
  parameter int unsigned FRAC = FxpFrac
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] k00,
  input  logic [N-1:0] k01,
  input  logic [N-1:0] k10,
  input  logic [N-1:0] k11,
  input  logic [N-1:0] h00,
  input  logic [N-1:0] h01,
  input  logic [N-1:0] h10,
  input  logic [N-1:0] h11,
  input  logic [N-1:0] p_prior00,
  input  logic [N-1:0] p_prior01,
  input  logic [N-1:0] p_prior10,
  input  logic [N-1:0] p_prior11,
  input  logic [N-1:0] x_prior0,
  input  logic [N-1:0] x_prior1,
  input  logic [N-1:0] z0,
  input  logic [N-1:0] z1,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] X_POST0,
  output logic [N-1:0] X_POST1,
  output logic [N-1:0] P_POST00,
  output logic [N-1:0] P_POST01,
  output logic [N-1:0] P_POST10,
  output logic [N-1:0] P_POST11
);

  localparam logic [N-1:0] One = N'(1 << FRAC);

  // Floor truncation with wrap: keep bits [FRAC+N-1:FRAC] of a 2N value.
  function automatic logic signed [N-1:0] trunc(input logic signed [2*N-1:0] y);
    return y[FRAC+N-1:FRAC];
  endfunction

  // Sign-extend an N-bit scalar and move it into the 2N product scale.
  function automatic logic signed [2*N-1:0] align(input logic signed [N-1:0] v);
    return {{(N-FRAC){v[N-1]}}, v, {FRAC{1'b0}}};
  endfunction

  upd_cyc_e cyc;

  // Shadow copies of the frame inputs, indexed row*2+col.
  logic signed [N-1:0] k_s [4];
  logic signed [N-1:0] h_s [4];
  logic signed [N-1:0] p_s [4];
  logic signed [N-1:0] x_s [2];
  logic signed [N-1:0] z_s [2];

  logic signed [N-1:0] e0, e1, xp0, xp1;
  logic signed [N-1:0] a00, a01, a10, a11;
  logic signed [N-1:0] pp00, pp10;

  logic signed [N-1:0]   op_a [4];
  logic signed [N-1:0]   op_b [4];
  logic                  mul_en;
  logic signed [2*N-1:0] s01, s23;

  logic accept;
  assign accept = start && !busy;

  // Frame control: accept, step the schedule, pulse done on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cyc  <= CycHx;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy <= 1'b1;
          cyc  <= CycHx;
        end
      end else if (cyc == CycPp1Out) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        cyc <= upd_cyc_e'(cyc + 4'd1);
      end
    end
  end

  // Capture all inputs on acceptance so the caller may change them mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_s <= '{default: '0};
      h_s <= '{default: '0};
      p_s <= '{default: '0};
      x_s <= '{default: '0};
      z_s <= '{default: '0};
    end else if (accept) begin
      k_s <= '{k00, k01, k10, k11};
      h_s <= '{h00, h01, h10, h11};
      p_s <= '{p_prior00, p_prior01, p_prior10, p_prior11};
      x_s <= '{x_prior0, x_prior1};
      z_s <= '{z0, z1};
    end
  end

  // Operand routing into the multiplier bank for each product-loading step.
  always_comb begin
    op_a   = '{default: '0};
    op_b   = '{default: '0};
    mul_en = busy && mul_load(cyc);
    case (cyc)
      CycHx: begin
        op_a = h_s;
        op_b = '{x_s[0], x_s[1], x_s[0], x_s[1]};
      end
      CycKe: begin
        op_a = k_s;
        op_b = '{e0, e1, e0, e1};
      end
      CycXpKh0: begin
        op_a = k_s;
        op_b = '{h_s[0], h_s[2], h_s[0], h_s[2]};
      end
      CycA0Kh1: begin
        op_a = k_s;
        op_b = '{h_s[1], h_s[3], h_s[1], h_s[3]};
      end
      CycAp0: begin
        op_a = '{a00, a01, a10, a11};
        op_b = '{p_s[0], p_s[2], p_s[0], p_s[2]};
      end
      CycPp0Ap1: begin
        op_a = '{a00, a01, a10, a11};
        op_b = '{p_s[1], p_s[3], p_s[1], p_s[3]};
      end
      default: ;
    endcase
  end

  kf_update_semipar_dot2x2 #(
    .N(N)
  ) u_dot (
    .clk(clk),
    .rst(rst),
    .en (mul_en),
    .a0 (op_a[0]),
    .b0 (op_b[0]),
    .a1 (op_a[1]),
    .b1 (op_b[1]),
    .a2 (op_a[2]),
    .b2 (op_b[2]),
    .a3 (op_a[3]),
    .b3 (op_b[3]),
    .s01(s01),
    .s23(s23)
  );

  // Intermediate results, each written on its own schedule step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0   <= '0;
      e1   <= '0;
      xp0  <= '0;
      xp1  <= '0;
      a00  <= '0;
      a01  <= '0;
      a10  <= '0;
      a11  <= '0;
      pp00 <= '0;
      pp10 <= '0;
    end else if (busy) begin
      case (cyc)
        CycErr: begin
          e0 <= z_s[0] - trunc(s01);
          e1 <= z_s[1] - trunc(s23);
        end
        CycXpKh0: begin
          xp0 <= trunc(align(x_s[0]) + s01);
          xp1 <= trunc(align(x_s[1]) + s23);
        end
        CycA0Kh1: begin
          a00 <= One - trunc(s01);
          a10 <= -trunc(s23);
        end
        CycA1: begin
          a01 <= -trunc(s01);
          a11 <= One - trunc(s23);
        end
        CycPp0Ap1: begin
          pp00 <= trunc(s01);
          pp10 <= trunc(s23);
        end
        default: ;
      endcase
    end
  end

  // Published results change only on the done edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      X_POST0  <= '0;
      X_POST1  <= '0;
      P_POST00 <= '0;
      P_POST01 <= '0;
      P_POST10 <= '0;
      P_POST11 <= '0;
    end else if (busy && cyc == CycPp1Out) begin
      X_POST0  <= xp0;
      X_POST1  <= xp1;
      P_POST00 <= pp00;
      P_POST10 <= pp10;
      P_POST01 <= trunc(s01);
      P_POST11 <= trunc(s23);
    end
  end

endmodule

// File: doc/kf_update_semipar.md
Name: kf_update_semipar

Overview:
- Measurement-update stage of the 2x2 fixed-point Kalman filter.
- Consumes the gain matrix K from the Kalman-gain block and computes x_post = x_prior + K(z - H x_prior) and P_post = (I - K H) P_prior.
- Reuses the semi-parallel style of the gain block: 4 full-precision multipliers with column sums in the 2N domain, on a fixed 9-cycle schedule.
- start ties directly to the gain block's done.

Parameters:
N, `FXP_N, total word width (signed two's complement)
FRAC, `FXP_FRAC, fractional bits

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request; ignored while busy
k00,k01,k10,k11  in  N each  Kalman gain
h00,h01,h10,h11  in  N each  observation matrix H
p_prior00,p_prior01,p_prior10,p_prior11  in  N each  prior covariance
x_prior0,x_prior1  in  N each  prior state
z0,z1  in  N each  measurement
busy  out  1  frame in progress
done  out  1  one-cycle pulse; results valid
X_POST0,X_POST1  out  N each  posterior state (registered)
P_POST00,P_POST01,P_POST10,P_POST11  out  N each  posterior covariance (registered)

Behaviour:
- Reset (asynchronous, active-high): all outputs, shadow registers, intermediates and the counter go to 0. busy=0, done=0.
- Start acceptance: on the edge that samples start=1 with busy=0, all inputs are captured into shadow registers, busy<=1 and cyc<=0. Inputs may change freely afterwards.
- start while busy is ignored, including the cycle of the final edge.
- Truncation: trunc(y) = y[FRAC+N-1:FRAC] of the 2N product/sum. This is floor truncation with wrap; there is no saturation.
- Scalar alignment: an N-bit term added to a 2N sum is sign-extended and shifted left by FRAC first.
- ONE = 1<<FRAC.
- Schedule (cyc k actions occur on edge k+1 after acceptance). The mul pair sums are s01 = m0+m1 and s23 = m2+m3, both 2N wide.
  - cyc0: mul x_prior0 against H row0/row1: m = h00*x0, h01*x1, h10*x0, h11*x1.
  - cyc1: e0 = z0 - trunc(s01); e1 = z1 - trunc(s23). N-bit wrap.
  - cyc2: m = k00*e0, k01*e1, k10*e0, k11*e1.
  - cyc3: xp0 = trunc(x0<<FRAC + s01); xp1 = trunc(x1<<FRAC + s23). Load m = k00*h00, k01*h10, k10*h00, k11*h10.
  - cyc4: a00 = ONE - trunc(s01); a10 = -trunc(s23). Load m = k00*h01, k01*h11, k10*h01, k11*h11.
  - cyc5: a01 = -trunc(s01); a11 = ONE - trunc(s23).
  - cyc6: m = a00*p00, a01*p10, a10*p00, a11*p10.
  - cyc7: pp00 = trunc(s01); pp10 = trunc(s23). Load m = a00*p01, a01*p11, a10*p01, a11*p11.
  - cyc8: pp01 = trunc(s01); pp11 = trunc(s23). Copy xp*/pp* to all outputs simultaneously; done<=1; busy<=0.
- Latency: done is high in the 9th cycle after the start-sampling edge.
- Outputs change only on the done edge and hold until the next done.
- The earliest next accept is on the edge after done goes high, so back-to-back throughput is 1 frame per 10 cycles.
- Reset mid-frame: the frame is aborted, no done is produced, outputs are 0, and a new start is accepted normally after rst falls.
- There is no symmetrisation of P_post; the bit-exact results are as scheduled above.

Decomposition:
- fxp_types.vh holds FXP_N and FXP_FRAC, plus two new macros: FXP_ONE and KF_UPD_LAST (=8).
- fxp_mul is reused as-is.
- One sub-module is natural: fxp_dot2x2. It has 4 fxp_mul instances plus two 2N adders, takes 8 operand inputs, and outputs s01/s23.
- The gain block's multiplier/column-sum pair can migrate to fxp_dot2x2 later.

Test Plan:
Bench uses N=16, FRAC=8.
1. Identity pass-through: H=I, K=0, x=(0x0100,0x0200), z=(0x7000,0x1234), P=[[0x0200,0x0100],[0x0100,0x0300]] -> X_POST=(0x0100,0x0200), P_POST=P; done exactly 9 cycles after start.
2. Half gain: H=I, K=0x0080*I, x=0, z=(0x0100,0xFE00), P=I -> X_POST=(0x0080,0xFF00), P_POST00=P_POST11=0x0080, off-diagonals 0.
3. Full gain: H=I, K=I, x=(0x0300,0x0400), z=(0x0100,0xFF80), P=[[0x0200,0x0100],[0x0100,0x0300]] -> X_POST=z, all P_POST=0.
4. Floor truncation: H=I, K=0x0080*I, x=0, z=(0xFFFF,0x0001), P=0 -> X_POST0=0xFFFF, X_POST1=0x0000.
5. Handshake: start held high for 25 cycles -> accepts at cycles 0, 10, 20 only; busy high 9 cycles per frame; done single-cycle at 9 and 19; extra pulses while busy are ignored.
6. Reset mid-frame: assert rst at cyc4 of a case-2 frame -> outputs/busy/done 0 immediately, no done afterwards; a following case-1 start produces case-1 results with correct latency.
